// File: rtl/layer_mac_pkg.sv
// Shared types and helpers for the layer MAC array: FSM state encoding,
// default geometry, and the round-half-up / saturate step applied per lane.
package layer_mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam int DEF_LANES = 10;
  localparam int DEF_DW    = 16;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_FRAC  = 8;
  localparam int DEF_K_LEN = 9;

  // Wide enough that the rounding add can never overflow for any legal ACC_W.
  localparam int RS_W = 128;

  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac,
    input int                     dw
  );
    logic signed [RS_W-1:0] one, r, hi, lo;
    one = RS_W'(1);
    r   = acc;
    if (frac > 0) r = r + (one <<< (frac - 1));
    r  = r >>> frac;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: signed multiply, wrapping accumulate, then round/saturate into
// a registered column word. Define LAYER_MAC_RELU_EN to clamp negatives to 0.
module mac_lane
  import layer_mac_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tap_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  logic signed [DW-1:0] pix_i,
  input  logic signed [DW-1:0] wgt_i,
  output logic        [DW-1:0] col_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x, sum, acc_q, acc_d;
  logic signed [RS_W-1:0]  rs;
  logic        [DW-1:0]    col_q, col_d;

  assign prod   = pix_i * wgt_i;
  assign prod_x = ACC_W'(prod);
  // First tap loads instead of adding, so no clear cycle between windows.
  assign sum    = first_i ? prod_x : acc_q + prod_x;

  always_comb begin
    rs    = round_sat(RS_W'(sum), FRAC, DW);
    acc_d = acc_q;
    col_d = col_q;
    if (tap_i) begin
      acc_d = sum;
      if (last_i) begin
`ifdef LAYER_MAC_RELU_EN
        col_d = rs[RS_W-1] ? '0 : rs[DW-1:0];
`else
        col_d = rs[DW-1:0];
`endif
      end
    end
  end

  // Saturated value must fit DW bits; the upper bits are pure sign extension.
  always_comb assert ((rs[RS_W-1:DW-1] == '0) || (&rs[RS_W-1:DW-1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      col_q <= '0;
    end else begin
      acc_q <= acc_d;
      col_q <= col_d;
    end
  end

  assign col_o = col_q;

endmodule

// File: rtl/layer_mac_array.sv
// LANES-wide windowed MAC with tap/result valid-ready framing. Build with
// LAYER_MAC_RELU_EN defined to get a fused ReLU on every lane result.
module layer_mac_array
  import layer_mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int K_LEN = DEF_K_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] pixels,
  input  logic [DW-1:0]       weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] column,
  output logic                busy
);

  localparam int CW = (K_LEN > 1) ? $clog2(K_LEN) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   tap_cnt_q, tap_cnt_d;
  logic            accept, first_tap, last_tap;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign first_tap = (tap_cnt_q == '0);
  assign last_tap  = (tap_cnt_q == CW'(K_LEN - 1));
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (last_tap) begin
            state_d   = HOLD;
            tap_cnt_d = '0;
          end else begin
            state_d   = ACCUM;
            tap_cnt_d = tap_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Handshake cycle takes no tap; next window starts a cycle later.
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        tap_cnt_d = '0;
      end
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .DW   (DW),
      .ACC_W(ACC_W),
      .FRAC (FRAC)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .tap_i  (accept),
      .first_i(first_tap),
      .last_i (last_tap),
      .pix_i  (pixels[g*DW +: DW]),
      .wgt_i  (weight),
      .col_o  (column[g*DW +: DW])
    );
  end

endmodule

// File: tb/tb_layer_mac_array.sv
// Randomised bench for layer_mac_array with a transaction-level reference
// model checked every cycle, plus literal spot checks on known windows.
module tb_layer_mac_array;

  localparam int LANES = 10;
  localparam int DW    = 16;
  localparam int ACC_W = 40;
  localparam int FRAC  = 8;
  localparam int K_LEN = 9;
  localparam int VW    = LANES * DW;
`ifdef LAYER_MAC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [VW-1:0] pixels, column;
  logic [DW-1:0] weight;

  int tests = 0;
  int fails = 0;

  layer_mac_array #(
    .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC), .K_LEN(K_LEN)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .weight(weight), .out_valid(out_valid),
    .out_ready(out_ready), .column(column), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic longint wrap_acc(input longint x);
    longint one, m;
    one = 1;
    m = x & ((one <<< ACC_W) - 1);
    if (((m >>> (ACC_W - 1)) & 1) != 0) m = m - (one <<< ACC_W);
    return m;
  endfunction

  function automatic logic [DW-1:0] lane_result(input longint s);
    longint r, hi, lo, one;
    logic [63:0] rb;
    one = 1;
    r  = s + ((FRAC > 0) ? (one <<< (FRAC - 1)) : 0);
    r  = r >>> FRAC;
    hi = (one <<< (DW - 1)) - 1;
    lo = -(one <<< (DW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    if (RELU && r < 0) r = 0;
    rb = r;
    return rb[DW-1:0];
  endfunction

  longint        m_sum [LANES];
  int            m_n    = 0;
  bit            m_hold = 1'b0;
  bit            m_fresh = 1'b0;
  bit            armed  = 1'b0;
  logic [VW-1:0] m_col  = '0;

  always @(negedge clk) begin
    if (armed) begin
      chk1("in_ready", in_ready, !m_hold);
      chk1("out_valid", out_valid, m_hold);
      chk1("busy", busy, m_hold || (m_n > 0));
      if (m_hold || m_fresh) chkv("column", column, m_col);
    end
    if (reset) begin
      m_n = 0; m_hold = 1'b0; m_col = '0; m_fresh = 1'b1; armed = 1'b1;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        longint p;
        p = longint'($signed(pixels[i*DW +: DW])) * longint'($signed(weight));
        m_sum[i] = wrap_acc((m_n == 0) ? p : m_sum[i] + p);
      end
      m_n++;
      if (m_n == K_LEN) begin
        for (int i = 0; i < LANES; i++) m_col[i*DW +: DW] = lane_result(m_sum[i]);
        m_hold = 1'b1; m_n = 0; m_fresh = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_tap(input logic [VW-1:0] px, input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; pixels = px; weight = w;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL tap_accept: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    chk1({name, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic uniform_window(input string name, input logic [DW-1:0] px,
                                input logic [DW-1:0] w, input logic [DW-1:0] lit);
    for (int t = 0; t < K_LEN; t++) send_tap(splat(px), w);
    wait_valid(name);
    chkv(name, column, splat(lit));
    handshake();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pixels = '0; weight = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkv("rst_column", column, '0);
    @(posedge clk); #1;

    // 0x100*0x200 over 9 taps -> 0x1200, result one cycle after last tap
    send_tap(splat(16'h0100), 16'h0200);
    @(negedge clk);
    chk1("busy_after_tap1", busy, 1'b1);
    @(posedge clk); #1;
    for (int t = 1; t < K_LEN; t++) send_tap(splat(16'h0100), 16'h0200);
    @(negedge clk);
    chk1("latency_valid", out_valid, 1'b1);
    chkv("basic_0x1200", column, splat(16'h1200));
    handshake();

    uniform_window("round_half_up", 16'h0001, 16'h0080, 16'h0005);
    uniform_window("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF);
    uniform_window("sat_neg", 16'h8000, 16'h7FFF, RELU ? 16'h0000 : 16'h8000);
    uniform_window("neg_9", 16'hFF00, 16'h0100, RELU ? 16'h0000 : 16'hF700);

    // backpressure: result held, taps offered but refused
    for (int t = 0; t < K_LEN; t++) send_tap(splat(16'h0100), 16'h0200);
    in_valid = 1'b1; pixels = splat(16'h0300); weight = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chkv("bp_column", column, splat(16'h1200));
      @(posedge clk); #1;
    end
    handshake();
    uniform_window("after_bp", 16'h0002, 16'h0100, 16'h0012);

    // reset mid-window discards partial sums
    for (int t = 0; t < 4; t++) send_tap(splat(16'h7000), 16'h7000);
    in_valid = 1'b1; reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    uniform_window("after_reset", 16'h0100, 16'h0100, 16'h0900);

    // randomised windows: gaps, idle out_ready noise, delayed handshakes
    for (int w = 0; w < 30; w++) begin
      logic [DW-1:0] wt;
      wt = (w % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1023)) - 16'd512;
      for (int t = 0; t < K_LEN; t++) begin
        logic [VW-1:0] px;
        int gap;
        for (int i = 0; i < LANES; i++)
          px[i*DW +: DW] = (w % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 4095)) - 16'd2048;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        send_tap(px, wt);
      end
      wait_valid("rand");
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      handshake();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
